// File: rtl/led_serialiser.sv
// led_serialiser
//   Latches a 24-bit colour word and drives it as a pulse-width-encoded single-wire
//   stream for a WS2812-class LED: 24 bit slots MSB first, then a low latch gap.
//
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset, priority over everything (aborts a frame)
//   light  - colour word {R[23:16], G[15:8], B[7:0]}
//   load   - send request, accepted on an edge where load && ready
//   ready  - high in IDLE only
//   busy   - inverse of ready
//   dout   - serial LED data line (registered, glitch-free)
//   done   - one-cycle pulse in the first IDLE cycle after a completed frame
module led_serialiser #(
  parameter int unsigned TBIT      = 125,
  parameter int unsigned T0H       = 40,
  parameter int unsigned T1H       = 80,
  parameter int unsigned TRESET    = 5000,
  parameter bit          GRB_ORDER = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] light,
  input  logic        load,
  output logic        ready,
  output logic        busy,
  output logic        dout,
  output logic        done
);

  // One counter serves both the bit slot and the latch gap.
  localparam int unsigned CntMax = (TBIT > TRESET) ? TBIT : TRESET;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] TbitLast   = CntW'(TBIT - 1);
  localparam logic [CntW-1:0] TresetLast = CntW'(TRESET - 1);
  localparam logic [CntW-1:0] T0hCnt     = CntW'(T0H);
  localparam logic [CntW-1:0] T1hCnt     = CntW'(T1H);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StLatch
  } state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cyc, w_cyc_d;
  logic [4:0]      r_bit, w_bit_d;
  logic [23:0]     r_shreg, w_shreg_d;
  logic            r_dout, w_dout_d;
  logic            r_done, w_done_d;
  logic [23:0]     w_light_ord;
  logic [CntW-1:0] w_high_len;

  assign w_light_ord = GRB_ORDER ? {light[15:8], light[23:16], light[7:0]} : light;

  always_comb begin
    w_state_d = r_state;
    w_cyc_d   = r_cyc;
    w_bit_d   = r_bit;
    w_shreg_d = r_shreg;
    w_done_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (load) begin
          w_shreg_d = w_light_ord;
          w_bit_d   = 5'd23;
          w_cyc_d   = '0;
          w_state_d = StSend;
        end
      end
      StSend: begin
        if (r_cyc == TbitLast) begin
          w_cyc_d = '0;
          if (r_bit == 5'd0) begin
            w_state_d = StLatch;
          end else begin
            w_shreg_d = {r_shreg[22:0], 1'b0};
            w_bit_d   = r_bit - 5'd1;
          end
        end else begin
          w_cyc_d = r_cyc + CntW'(1);
        end
      end
      StLatch: begin
        if (r_cyc == TresetLast) begin
          w_cyc_d   = '0;
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end else begin
          w_cyc_d = r_cyc + CntW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // dout is derived from next-state values and registered, so the line rises in the
  // cycle right after the accepting edge and never glitches.
  assign w_high_len = w_shreg_d[23] ? T1hCnt : T0hCnt;
  assign w_dout_d   = (w_state_d == StSend) && (w_cyc_d < w_high_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_dout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cyc   <= w_cyc_d;
      r_bit   <= w_bit_d;
      r_shreg <= w_shreg_d;
      r_dout  <= w_dout_d;
      r_done  <= w_done_d;
    end
  end

  assign ready = (r_state == StIdle);
  assign busy  = ~ready;
  assign dout  = r_dout;
  assign done  = r_done;

endmodule

// File: tb/tb_led_serialiser.sv
// Bench for led_serialiser: two instances (RGB and GRB order) share all inputs and are
// compared every cycle against a frame-level model of the expected line waveform.
module tb_led_serialiser;

  localparam int TBIT   = 10;
  localparam int T0H    = 3;
  localparam int T1H    = 7;
  localparam int TRESET = 20;
  localparam int NBITS  = 24 * TBIT;
  localparam int FRAME  = NBITS + TRESET;  // interval index of the done cycle

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] light;
  logic        load;
  logic        ready_rgb, busy_rgb, dout_rgb, done_rgb;
  logic        ready_grb, busy_grb, dout_grb, done_grb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_serialiser #(
    .TBIT(TBIT), .T0H(T0H), .T1H(T1H), .TRESET(TRESET), .GRB_ORDER(1'b0)
  ) u_dut_rgb (
    .clk(clk), .rst(rst), .light(light), .load(load),
    .ready(ready_rgb), .busy(busy_rgb), .dout(dout_rgb), .done(done_rgb)
  );

  led_serialiser #(
    .TBIT(TBIT), .T0H(T0H), .T1H(T1H), .TRESET(TRESET), .GRB_ORDER(1'b1)
  ) u_dut_grb (
    .clk(clk), .rst(rst), .light(light), .load(load),
    .ready(ready_grb), .busy(busy_grb), .dout(dout_grb), .done(done_grb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level at interval k (k=0 is the cycle after the accepting edge).
  function automatic logic exp_line(input logic [23:0] w, input int k);
    int   slot;
    int   ph;
    logic b;
    if (k >= NBITS) return 1'b0;
    slot = k / TBIT;
    ph   = k % TBIT;
    b    = w[23 - slot];
    return ph < (b ? T1H : T0H);
  endfunction

  // Frame-level model
  bit          m_active = 1'b0;
  int          m_k      = 0;
  logic [23:0] m_w_rgb  = '0;
  logic [23:0] m_w_grb  = '0;
  int          m_done_cnt = 0;
  int          dut_done_cnt = 0;

  always @(posedge clk) begin
    logic m_ready;
    logic e_dout_rgb, e_dout_grb, e_ready, e_done;
    m_ready = !m_active || (m_k == FRAME);
    if (rst) begin
      m_active = 1'b0;
    end else if (m_ready && load) begin
      m_active = 1'b1;
      m_k      = 0;
      m_w_rgb  = light;
      m_w_grb  = {light[15:8], light[23:16], light[7:0]};
    end else if (m_active) begin
      m_k++;
      if (m_k > FRAME) m_active = 1'b0;
    end
    e_ready    = !m_active || (m_k == FRAME);
    e_done     = m_active && (m_k == FRAME);
    e_dout_rgb = m_active && exp_line(m_w_rgb, m_k);
    e_dout_grb = m_active && exp_line(m_w_grb, m_k);
    if (e_done) m_done_cnt++;
    #1;
    if (done_rgb === 1'b1) dut_done_cnt++;
    check("dout_rgb", 32'(dout_rgb), 32'(e_dout_rgb));
    check("dout_grb", 32'(dout_grb), 32'(e_dout_grb));
    check("ready", 32'(ready_rgb), 32'(e_ready));
    check("busy", 32'(busy_grb), 32'(!e_ready));
    check("done_rgb", 32'(done_rgb), 32'(e_done));
    check("done_grb", 32'(done_grb), 32'(e_done));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b1;
    light = 24'h123456;
    tick(2);
    rst  = 1'b0;
    load = 1'b0;
    tick(5);

    // Single frame, blue only
    light = 24'h0000FF;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
    light = 24'hA5A5A5;  // post-accept change must not matter
    tick(FRAME + 10);

    // Red only: GRB instance sends it in the middle byte
    light = 24'hFF0000;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
    tick(FRAME + 5);

    // Load while busy is ignored
    light = 24'hFFFFFF;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
    tick(49);
    light = 24'h000000;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
    tick(FRAME);

    // Back-to-back with load held
    light = 24'h00FF00;
    load  = 1'b1;
    tick(3 * (FRAME + 1) + 4);
    load  = 1'b0;
    tick(FRAME + 5);

    // Mid-frame reset, then a clean frame
    light = 24'hC3C3C3;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
    tick(99);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    light = 24'h5A0F81;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
    tick(FRAME + 5);

    // Randomized traffic
    for (int i = 0; i < 16; i++) begin
      light = 24'($urandom);
      load  = 1'b1;
      tick(int'($urandom_range(1, 3)));
      load = 1'b0;
      for (int j = 0; j < 4; j++) begin
        light = 24'($urandom);
        tick(int'($urandom_range(10, 90)));
      end
      if ($urandom_range(0, 3) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
    end
    tick(FRAME + 5);

    check("done_count", 32'(dut_done_cnt), 32'(m_done_cnt));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
